// File: rtl/seven_seg_scanner_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment scanner:
// FSM state encoding, digit width, anode pattern and counter sizing helpers.
package seven_seg_scanner_pkg;

    localparam int DIGIT_W    = 4;
    localparam int MAX_DIGITS = 8;

    localparam logic [0:0] ST_SHOW = 1'b0;
    localparam logic [0:0] ST_GAP  = 1'b1;

    function automatic logic [MAX_DIGITS-1:0] anode_blank();
        return {MAX_DIGITS{1'b1}};
    endfunction

    function automatic logic [MAX_DIGITS-1:0] anode_lit(input logic [2:0] idx);
        return ~({{(MAX_DIGITS-1){1'b0}}, 1'b1} << idx);
    endfunction

    // Wide enough to count to max(a,b)-1, never narrower than one bit.
    function automatic int cnt_width(input int a, input int b);
        int m;
        int w;
        m = (a > b) ? a : b;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/seven_seg_scanner_seg_refresh_timer.sv
// Slot timer for the scanner: free-running count cleared on every state or
// digit change, with terminal-count flags for the SHOW and GAP lengths.
module seg_refresh_timer
    import seven_seg_scanner_pkg::*;
#(
    parameter int SHOW_LEN = 4,
    parameter int GAP_LEN  = 1,
    parameter int CNT_W    = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic show_tc,
    output logic gap_tc
);

    localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SHOW_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = (GAP_LEN > 0) ? CNT_W'(GAP_LEN - 1) : {CNT_W{1'b0}};
    localparam logic             HAS_GAP   = (GAP_LEN > 0);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count and terminal-count decode.
    always_comb begin
        show_tc = (cnt_q == SHOW_LAST);
        gap_tc  = HAS_GAP && (cnt_q == GAP_LAST);
        if (clr) begin
            cnt_d = {CNT_W{1'b0}};
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Four-digit (parameterisable) multiplexed 7-segment scanner with frame-aligned
// double buffering. Optional leading-zero blanking under macro SEVSEG_LZB_EN.
module seven_seg_scanner
    import seven_seg_scanner_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    output logic [DIGIT_W-1:0]            bcd,
    output logic                          dp,
    output logic [NUM_DIGITS-1:0]         an,
    output logic                          pending,
    output logic                          frame_done
);

    localparam int   IDX_W   = $clog2(NUM_DIGITS);
    localparam int   CNT_W   = cnt_width(REFRESH_DIV, BLANK_CYCLES);
    localparam int   VAL_W   = DIGIT_W * NUM_DIGITS;
    localparam logic HAS_GAP = (BLANK_CYCLES > 0);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [0:0]            state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [VAL_W-1:0]      shadow_val_q, shadow_val_d;
    logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
    logic [VAL_W-1:0]      active_val_q, active_val_d;
    logic [NUM_DIGITS-1:0] active_dp_q, active_dp_d;
    logic                  pending_q, pending_d;
    logic [DIGIT_W-1:0]    bcd_q, bcd_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  frame_done_q, frame_done_d;

    logic show_tc_s;
    logic gap_tc_s;
    logic clr_s;
    logic slot_end_s;
    logic commit_s;
    logic [DIGIT_W-1:0] digit_s;
    logic dp_sel_s;
`ifdef SEVSEG_LZB_EN
    logic upper_nz_s;
`endif

    seg_refresh_timer #(
        .SHOW_LEN (REFRESH_DIV),
        .GAP_LEN  (BLANK_CYCLES),
        .CNT_W    (CNT_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr_s),
        .show_tc (show_tc_s),
        .gap_tc  (gap_tc_s)
    );

    // Slot sequencing; a zero-length gap chains SHOW slots back to back.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        clr_s      = 1'b0;
        slot_end_s = 1'b0;
        case (state_q)
            ST_SHOW: begin
                if (show_tc_s) begin
                    clr_s = 1'b1;
                    if (HAS_GAP) begin
                        state_d = ST_GAP;
                    end else begin
                        slot_end_s = 1'b1;
                    end
                end else begin
                    state_d = ST_SHOW;
                end
            end
            ST_GAP: begin
                if (gap_tc_s) begin
                    clr_s      = 1'b1;
                    slot_end_s = 1'b1;
                    state_d    = ST_SHOW;
                end else begin
                    state_d = ST_GAP;
                end
            end
            default: begin
                clr_s   = 1'b1;
                state_d = ST_SHOW;
            end
        endcase
        if (slot_end_s) begin
            idx_d = (idx_q == IDX_LAST) ? {IDX_W{1'b0}} : idx_q + IDX_W'(1);
        end else begin
            idx_d = idx_q;
        end
        commit_s     = slot_end_s && (idx_q == IDX_LAST);
        frame_done_d = commit_s;
    end

    // Double buffer: a load on the commit cycle bypasses the shadow.
    always_comb begin
        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;
        active_val_d = active_val_q;
        active_dp_d  = active_dp_q;
        pending_d    = pending_q;
        if (load) begin
            shadow_val_d = value_in;
            shadow_dp_d  = dp_in;
        end else begin
            shadow_val_d = shadow_val_q;
            shadow_dp_d  = shadow_dp_q;
        end
        if (commit_s) begin
            pending_d = 1'b0;
            if (load) begin
                active_val_d = value_in;
                active_dp_d  = dp_in;
            end else if (pending_q) begin
                active_val_d = shadow_val_q;
                active_dp_d  = shadow_dp_q;
            end else begin
                active_val_d = active_val_q;
                active_dp_d  = active_dp_q;
            end
        end else if (load) begin
            pending_d = 1'b1;
        end else begin
            pending_d = pending_q;
        end
    end

    // Current digit selection and display output decode.
    always_comb begin
        digit_s  = {DIGIT_W{1'b0}};
        dp_sel_s = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            digit_s  = digit_s | ((idx_q == IDX_W'(i)) ? active_val_q[DIGIT_W*i +: DIGIT_W] : {DIGIT_W{1'b0}});
            dp_sel_s = dp_sel_s | ((idx_q == IDX_W'(i)) && active_dp_q[i]);
        end
`ifdef SEVSEG_LZB_EN
        upper_nz_s = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            upper_nz_s = upper_nz_s |
                         ((IDX_W'(i) >= idx_q) && (active_val_q[DIGIT_W*i +: DIGIT_W] != {DIGIT_W{1'b0}}));
        end
`endif
        an_d  = NUM_DIGITS'(anode_blank());
        bcd_d = bcd_q;
        dp_d  = 1'b0;
        if (state_q == ST_SHOW) begin
            bcd_d = digit_s;
            dp_d  = dp_sel_s;
`ifdef SEVSEG_LZB_EN
            if ((idx_q != {IDX_W{1'b0}}) && !upper_nz_s) begin
                an_d = NUM_DIGITS'(anode_blank());
            end else begin
                an_d = NUM_DIGITS'(anode_lit(3'(idx_q)));
            end
`else
            an_d = NUM_DIGITS'(anode_lit(3'(idx_q)));
`endif
        end else begin
            an_d  = NUM_DIGITS'(anode_blank());
            bcd_d = bcd_q;
            dp_d  = 1'b0;
        end
    end

    // State, buffer and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_SHOW;
            idx_q        <= {IDX_W{1'b0}};
            shadow_val_q <= {VAL_W{1'b0}};
            shadow_dp_q  <= {NUM_DIGITS{1'b0}};
            active_val_q <= {VAL_W{1'b0}};
            active_dp_q  <= {NUM_DIGITS{1'b0}};
            pending_q    <= 1'b0;
            bcd_q        <= {DIGIT_W{1'b0}};
            dp_q         <= 1'b0;
            an_q         <= {NUM_DIGITS{1'b1}};
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            active_val_q <= active_val_d;
            active_dp_q  <= active_dp_d;
            pending_q    <= pending_d;
            bcd_q        <= bcd_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bcd        = bcd_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign pending    = pending_q;
    assign frame_done = frame_done_q;

endmodule
